mac_accumulator_4x4: RTL and testbench

Sequential multiply-accumulate stage built around the 4x4 combinational array multiplier. It accepts a burst of `len` 4-bit operand pairs over a valid/ready handshake and registers each pair. It feeds each pair through the multiplier and sums the 8-bit products into a wide accumulator. It then presents the final sum downstream on a valid/ready result port.

---
 rtl/mac_pkg.sv | 14 +
 rtl/mac_accumulator_4x4_mult.sv | 18 +
 rtl/mac_accumulator_4x4.sv | 131 +++++++++++++
 tb/tb_mac_accumulator_4x4.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and widths for the 4x4 multiply-accumulate stage.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mac_state_e;

   localparam int MULT_W = 4;
   localparam int PROD_W = 8;

endpackage

// File: rtl/mac_accumulator_4x4_mult.sv
// Combinational 4x4 unsigned array multiplier: sum of shifted, gated partial products.
module four_bit_multiplier
   import mac_pkg::*;
(
   input  logic [MULT_W-1:0] a_i,
   input  logic [MULT_W-1:0] b_i,
   output logic [PROD_W-1:0] prod_o
);

   // Accumulate one partial-product row per multiplier bit.
   always_comb begin
      prod_o = {PROD_W{1'b0}};
      for (int i = 0; i < MULT_W; i++) begin
         prod_o = prod_o + ({{(PROD_W-MULT_W){1'b0}}, a_i & {MULT_W{b_i[i]}}} << i);
      end
   end

endmodule

// File: rtl/mac_accumulator_4x4.sv
// Burst multiply-accumulate: registered operand pipe, 4x4 multiplier, wide sticky-overflow accumulator.
module mac_accumulator_4x4
   import mac_pkg::*;
#(
   parameter int ACC_W = 16,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_a,
   input  logic [3:0]       in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   mac_state_e        state_q, state_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic              pipe_v_q, pipe_v_d;
   logic [MULT_W-1:0] pipe_a_q, pipe_a_d;
   logic [MULT_W-1:0] pipe_b_q, pipe_b_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              ovf_q, ovf_d;
   logic [PROD_W-1:0] prod_s;
   logic [ACC_W:0]    sum_s;
   logic              hs_s;

   four_bit_multiplier u_mult (
      .a_i    (pipe_a_q),
      .b_i    (pipe_b_q),
      .prod_o (prod_s)
   );

   assign sum_s     = {1'b0, acc_q} + {{(ACC_W+1-PROD_W){1'b0}}, prod_s};
   assign in_ready  = (state_q == ACCUM);
   assign hs_s      = in_valid & in_ready;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_acc   = acc_q;
   assign out_ovf   = ovf_q;

   // Next-state logic for FSM, burst counter, operand pipe and accumulator.
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      pipe_v_d = 1'b0;
      pipe_a_d = pipe_a_q;
      pipe_b_d = pipe_b_q;
      acc_d    = acc_q;
      ovf_d    = ovf_q;

      if (pipe_v_q) begin
         acc_d = sum_s[ACC_W-1:0];
         ovf_d = ovf_q | sum_s[ACC_W];
      end else begin
         acc_d = acc_q;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d = {ACC_W{1'b0}};
               ovf_d = 1'b0;
               rem_d = len;
               // An empty burst still spends one cycle in DRAIN so out_valid lands one edge after start.
               if (len == {CNT_W{1'b0}}) begin
                  state_d = DRAIN;
               end else begin
                  state_d = ACCUM;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACCUM: begin
            if (hs_s) begin
               pipe_v_d = 1'b1;
               pipe_a_d = in_a;
               pipe_b_d = in_b;
               rem_d    = rem_q - CNT_ONE;
               if (rem_q == CNT_ONE) begin
                  state_d = DRAIN;
               end else begin
                  state_d = ACCUM;
               end
            end else begin
               state_d = ACCUM;
            end
         end
         DRAIN: state_d = DONE;
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, pipe and accumulator registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rem_q    <= {CNT_W{1'b0}};
         pipe_v_q <= 1'b0;
         pipe_a_q <= {MULT_W{1'b0}};
         pipe_b_q <= {MULT_W{1'b0}};
         acc_q    <= {ACC_W{1'b0}};
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         pipe_v_q <= pipe_v_d;
         pipe_a_q <= pipe_a_d;
         pipe_b_q <= pipe_b_d;
         acc_q    <= acc_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule

// File: tb/tb_mac_accumulator_4x4.sv
// Scoreboard bench: drives a 16-bit and an 8-bit accumulator in lockstep and checks each result.
module tb_mac_accumulator_4x4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  len = 4'd0;
   logic        in_valid = 1'b0;
   logic [3:0]  in_a = 4'd0;
   logic [3:0]  in_b = 4'd0;
   logic        out_ready = 1'b1;

   logic        in_ready16, out_valid16, out_ovf16, busy16;
   logic [15:0] out_acc16;
   logic        in_ready8, out_valid8, out_ovf8, busy8;
   logic [7:0]  out_acc8;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t0 = 0;
   int pa[16];
   int pb[16];

   typedef struct {
      logic [15:0] acc16;
      logic        ovf16;
      logic [7:0]  acc8;
      logic        ovf8;
      int          lat;
   } exp_t;

   exp_t sbq[$];

   mac_accumulator_4x4 #(.ACC_W(16), .CNT_W(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16),
      .out_ovf(out_ovf16), .busy(busy16)
   );

   mac_accumulator_4x4 #(.ACC_W(8), .CNT_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid8), .out_ready(out_ready), .out_acc(out_acc8),
      .out_ovf(out_ovf8), .busy(busy8)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Result monitor: pops one expectation on each rising out_valid.
   logic prev_v = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (out_valid16 && !prev_v) begin
         if (sbq.size() == 0) begin
            check_val("unexpected_result", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            check_val("acc16", out_acc16, e.acc16);
            check_val("ovf16", out_ovf16, e.ovf16);
            check_val("valid8", out_valid8, 1);
            check_val("acc8", out_acc8, e.acc8);
            check_val("ovf8", out_ovf8, e.ovf8);
            check_val("latency", cyc - t0, e.lat);
         end
      end
      prev_v = out_valid16;
   end

   task automatic push_expected(input int n, input int lat);
      exp_t e;
      int a16 = 0, a8 = 0, t;
      logic o16 = 1'b0, o8 = 1'b0;
      for (int i = 0; i < n; i++) begin
         t = a16 + pa[i] * pb[i];
         if (t > 65535) o16 = 1'b1;
         a16 = t % 65536;
         t = a8 + pa[i] * pb[i];
         if (t > 255) o8 = 1'b1;
         a8 = t % 256;
      end
      e.acc16 = 16'(a16);
      e.ovf16 = o16;
      e.acc8  = 8'(a8);
      e.ovf8  = o8;
      e.lat   = lat;
      sbq.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_in_ready"}, {in_ready16, in_ready8}, 0);
      check_val({tag, "_out_valid"}, {out_valid16, out_valid8}, 0);
      check_val({tag, "_acc"}, {out_acc16, out_acc8}, 0);
      check_val({tag, "_ovf"}, {out_ovf16, out_ovf8}, 0);
      check_val({tag, "_busy"}, {busy16, busy8}, 0);
   endtask

   // Runs one burst from pa/pb with `bubbles` idle cycles before every pair after the first.
   task automatic run_burst(input int n, input int bubbles, input bit hold);
      int k;
      push_expected(n, (n == 0) ? 1 : n + 1 + bubbles * (n - 1));
      @(negedge clk);
      start = 1'b1;
      len   = 4'(n);
      @(posedge clk);
      #1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            for (int j = 0; j < bubbles; j++) begin
               in_valid = 1'b0;
               @(negedge clk);
            end
         end
         in_valid = 1'b1;
         in_a = 4'(pa[i]);
         in_b = 4'(pb[i]);
         k = 0;
         while (!in_ready16 && k < 20) begin
            @(negedge clk);
            k++;
         end
         if (k == 20) check_val("in_ready_timeout", 32'd0, 32'd1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (hold) begin
         k = 0;
         while (!out_valid16 && k < 100) begin
            @(negedge clk);
            k++;
         end
         if (k == 100) check_val("out_valid_timeout", 32'd0, 32'd1);
      end else begin
         k = 0;
         while ((busy16 || out_valid16) && k < 100) begin
            if (n == 0) check_val("in_ready_len0", in_ready16, 0);
            @(negedge clk);
            k++;
         end
         if (k == 100) check_val("idle_timeout", 32'd0, 32'd1);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("post_reset");

      pa[0] = 15; pb[0] = 15; pa[1] = 15; pb[1] = 15; pa[2] = 1; pb[2] = 1;
      run_burst(3, 0, 1'b0);

      run_burst(2, 0, 1'b0);

      run_burst(0, 0, 1'b0);

      pa[0] = 3; pb[0] = 5; pa[1] = 7; pb[1] = 2;
      run_burst(2, 2, 1'b0);

      for (int i = 0; i < 15; i++) begin
         pa[i] = 15;
         pb[i] = 15;
      end
      run_burst(15, 0, 1'b0);

      for (int r = 0; r < 3; r++) begin
         int n;
         n = $urandom_range(1, 15);
         for (int i = 0; i < n; i++) begin
            pa[i] = $urandom_range(0, 15);
            pb[i] = $urandom_range(0, 15);
         end
         run_burst(n, r, 1'b0);
      end

      // DONE hold with start pulses, then a start coinciding with the out_ready handshake.
      out_ready = 1'b0;
      pa[0] = 9; pb[0] = 9;
      run_burst(1, 0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         start = ~start;
         len   = 4'd3;
         @(negedge clk);
         check_val("hold_valid", out_valid16, 1);
         check_val("hold_acc16", out_acc16, 81);
         check_val("hold_acc8", out_acc8, 81);
         check_val("hold_ovf", {out_ovf16, out_ovf8}, 0);
      end
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("release_busy", busy16, 0);
      check_val("release_valid", out_valid16, 0);
      pa[0] = 4; pb[0] = 6; pa[1] = 2; pb[1] = 2;
      run_burst(2, 0, 1'b0);

      // Abort a len=4 burst after two accepted pairs.
      @(negedge clk);
      start = 1'b1;
      len   = 4'd4;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      in_a = 4'd6; in_b = 4'd7;
      @(negedge clk);
      in_a = 4'd5; in_b = 4'd5;
      @(negedge clk);
      check_val("pre_abort_acc16", out_acc16, 42);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pa[0] = 2; pb[0] = 3; pa[1] = 4; pb[1] = 5;
      run_burst(2, 0, 1'b0);

      check_val("sb_empty", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
